unpacker: RTL and testbench
===========================

# unpacker

Sparse bit unpacker: the inverse of the team's bit packer. It accepts a stream of densely packed bytes and scatters the bits, LSB-first in arrival order, into the bit positions selected by a per-request mask. The block sits on the receive side of a link that carries packer output, and restores each original sparse `data`/`data_valid` word. A small shift buffer holds bits that have arrived but not yet been consumed.

## Interface

- `W`, default 8: word width for the input, request and output words. The internal buffer is 2·W bits wide.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `in_data` in W: packed bits. Bit 0 is the oldest.
- `in_valid` in 1: `in_data` is present.
- `in_ready` out 1: the buffer can accept a full word.
- `req_mask` in W: positions to fill in the next output word.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: the buffer holds at least popcount(`req_mask`) bits.
- `out_data` out W: unpacked word. Unmasked bits are 0.
- `out_mask` out W: copy of the accepted `req_mask`.
- `out_valid` out 1: single-cycle pulse. There is no output backpressure.

## Operation

**State**
- `buf` is 2·W bits; valid bits sit at [count-1:0].
- `count` is a $clog2(2W+1)-bit value in the range 0..2W.
- `out_data`, `out_mask` and `out_valid` are registers.

**Ready signals** (combinational from registered state only)
- `in_ready` = (`count` ≤ W).
- `req_ready` = (`count` ≥ popcount(`req_mask`)).

**Transfers**
- Input accepted: `in_valid & in_ready`.
- Request accepted: `req_valid & req_ready`.
- Both may happen in the same cycle.

**Request consume**, with n = popcount(`req_mask`):
- For each set mask bit in ascending position order, assign the next bit `buf[0]`, `buf[1]`, ….
- Set `out_data` at those positions; clear all others.
- Shift `buf` right by n and decrement `count` by n.
- n = 0 is legal: always ready, produces `out_data` = 0 with `out_valid` = 1.

**Input append**
- Write `in_data` at `buf[count' +: W]`, where `count'` = `count` after this cycle's consume.
- `count` increases by W.

**Simultaneous transfers**
- A request consumes only bits present before this edge; the same-cycle input is never used by that request.
- Final `count` = `count` − n + W.

**Width rule**
- `count` never exceeds 2W, because input is accepted only when `count` ≤ W.

There is no FSM beyond the buffer occupancy.

## Timing

- Reset (asynchronous assert, synchronous-style release): `count` = 0, `buf` = 0, `out_data` = 0, `out_mask` = 0, `out_valid` = 0.
  - Consequently `in_ready` = 1, and `req_ready` = 1 only for an all-zero mask.
- Latency is 1 cycle: a request accepted at edge k gives `out_valid` = 1 with its data after edge k, held for exactly one cycle.
- `out_valid` = 0 in any cycle following an edge with no accepted request; `out_data` and `out_mask` hold their values.
- Back-to-back requests are supported: one output per cycle while `req_ready` stays high.
- An input written at edge k is usable by a request accepted at edge k+1 or later.
- Full condition: at `count` > W, `in_ready` = 0 and input stalls; the upstream holds `in_data` stable.
- Empty/short condition: at `count` < n, the request stalls; `req_ready` = 0 and the requester holds `req_mask` stable.
- Reset mid-operation: all buffered bits are dropped, and any `out_valid` pulse in flight is cleared immediately.

## Test plan

1. **Round-trip of the packer's pattern.** Push `in_data` 1110_1010, then 0000_0001. Request 1001_1010, then 0100_1111.
   - Required: `out_data` 1000_1000, then 0100_1110.
   - Required: `count` ends at 7.
2. **Short stall.** With `count` = 3, request 1111_0000.
   - Required: `req_ready` = 0 and no `out_valid`.
   - Push 0000_1111. Required: the request fires on the next cycle, giving `out_data` = 1111_0000 with bits taken as the 3 old bits followed by new bit 0.
3. **Full stall.** Push three words with no requests.
   - Required: `in_ready` drops after the second word (`count` = 16).
   - Request mask FF. Required: `in_ready` = 1 again with `count` = 8.
4. **Simultaneous transfers.** With `count` = 8, in the same cycle push 0x55 and request 0x0F.
   - Required: `out_data` uses only the old bits.
   - Required: `count` = 12, and new data sits at `buf[11:4]`.
5. **Zero mask.** With `count` = 0, request 0x00.
   - Required: immediate accept, then `out_valid` = 1 with `out_data` = 0 and `out_mask` = 0.
6. **Mid-operation reset.** Assert `reset` low while `count` = 5 and `out_valid` = 1.
   - Required: all outputs are 0 asynchronously.
   - Required: after release, `count` = 0 and `in_ready` = 1.

Source files
------------

// File: rtl/unpacker.sv
// Sparse bit unpacker: scatters densely packed input bits, LSB-first in arrival order,
// into the positions selected by each request mask. A 2W-bit shift buffer holds pending bits.
module unpacker #(
  parameter int unsigned W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] req_mask,
  input  logic         req_valid,
  output logic         req_ready,
  output logic [W-1:0] out_data,
  output logic [W-1:0] out_mask,
  output logic         out_valid
);

  localparam int unsigned BW = 2 * W;
  localparam int unsigned CW = $clog2(BW + 1);

  logic [BW-1:0] buf_q, buf_d, buf_shift;
  logic [CW-1:0] count_q, count_d, count_mid;
  logic [CW-1:0] req_n;
  logic [W-1:0]  scatter;
  logic          in_fire, req_fire;

  // Number of bits the pending request will consume.
  always_comb begin
    req_n = '0;
    for (int i = 0; i < W; i++) begin
      req_n = req_n + CW'(req_mask[i]);
    end
  end

  assign in_ready  = (count_q <= CW'(W));
  assign req_ready = (count_q >= req_n);
  assign in_fire   = in_valid & in_ready;
  assign req_fire  = req_valid & req_ready;

  // Walk the mask in ascending order, handing out the oldest buffered bit each time.
  always_comb begin
    logic [BW-1:0] pend;
    pend    = buf_q;
    scatter = '0;
    for (int i = 0; i < W; i++) begin
      if (req_mask[i]) begin
        scatter[i] = pend[0];
        pend       = pend >> 1;
      end
    end
  end

  // Consume first, then append at the post-consume fill level; bits above count stay zero.
  always_comb begin
    buf_shift = buf_q;
    count_mid = count_q;
    if (req_fire) begin
      buf_shift = buf_q >> req_n;
      count_mid = count_q - req_n;
    end
    buf_d   = buf_shift;
    count_d = count_mid;
    if (in_fire) begin
      buf_d   = buf_shift | (BW'(in_data) << count_mid);
      count_d = count_mid + CW'(W);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_q     <= '0;
      count_q   <= '0;
      out_data  <= '0;
      out_mask  <= '0;
      out_valid <= 1'b0;
    end else begin
      buf_q     <= buf_d;
      count_q   <= count_d;
      out_valid <= req_fire;
      if (req_fire) begin
        out_data <= scatter;
        out_mask <= req_mask;
      end
    end
  end

endmodule

// File: tb/tb_unpacker.sv
// Self-checking bench for unpacker: directed scenarios plus random traffic,
// checked against a bit-queue reference model.
module tb_unpacker;

  localparam int unsigned W = 8;

  logic         clock;
  logic         reset;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] req_mask;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] out_data;
  logic [W-1:0] out_mask;
  logic         out_valid;

  unpacker #(.W(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .req_mask (req_mask),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .out_data (out_data),
    .out_mask (out_mask),
    .out_valid(out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: pending bits, oldest at the front.
  bit           model_q[$];
  logic [W-1:0] exp_data;
  logic [W-1:0] exp_mask;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check readies, predict, clock, check outputs and fill level.
  task automatic step(input logic iv, input logic [W-1:0] id, input logic rv,
                      input logic [W-1:0] rm);
    int  sz;
    bit  acc_in, acc_rq;
    in_valid  = iv;
    in_data   = id;
    req_valid = rv;
    req_mask  = rm;
    #1;
    sz     = model_q.size();
    acc_in = iv && (sz <= W);
    acc_rq = rv && (sz >= $countones(rm));
    chk("in_ready", 32'(in_ready), 32'(sz <= W));
    chk("req_ready", 32'(req_ready), 32'(sz >= $countones(rm)));
    if (acc_rq) begin
      exp_data = '0;
      exp_mask = rm;
      for (int i = 0; i < W; i++) begin
        if (rm[i]) exp_data[i] = model_q.pop_front();
      end
    end
    if (acc_in) begin
      for (int i = 0; i < W; i++) model_q.push_back(id[i]);
    end
    @(posedge clock);
    #1;
    chk("out_valid", 32'(out_valid), 32'(acc_rq));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("out_mask", 32'(out_mask), 32'(exp_mask));
    chk("count", 32'(dut.count_q), 32'(model_q.size()));
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    req_valid = 1'b0;
    in_data   = '0;
    req_mask  = '0;
    reset     = 1'b0;
    model_q.delete();
    exp_data = '0;
    exp_mask = '0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    req_valid = 1'b0;
    in_data = '0;
    req_mask = '0;
    #2;
    do_reset();
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_req_ready_ff", 32'(req_ready), 32'd1);
    req_mask = 8'h01;
    #1;
    chk("rst_req_ready_01", 32'(req_ready), 32'd0);

    // Round trip of the packer pattern.
    step(1'b1, 8'b1110_1010, 1'b0, 8'h00);
    step(1'b1, 8'b0000_0001, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 8'b1001_1010);
    chk("rt_word0", 32'(out_data), 32'b1000_1000);
    step(1'b0, 8'h00, 1'b1, 8'b0100_1111);
    chk("rt_word1", 32'(out_data), 32'b0100_1110);
    chk("rt_count", 32'(dut.count_q), 32'd7);

    // Short stall: three ones buffered, request needs four.
    do_reset();
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 8'h1F);
    chk("short_count3", 32'(dut.count_q), 32'd3);
    step(1'b0, 8'h00, 1'b1, 8'hF0);
    chk("short_no_valid", 32'(out_valid), 32'd0);
    step(1'b1, 8'h0F, 1'b1, 8'hF0);
    step(1'b0, 8'h00, 1'b1, 8'hF0);
    chk("short_fire", 32'(out_data), 32'hF0);

    // Full stall.
    do_reset();
    step(1'b1, 8'h11, 1'b0, 8'h00);
    step(1'b1, 8'h22, 1'b0, 8'h00);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    step(1'b1, 8'h33, 1'b0, 8'h00);
    step(1'b1, 8'h33, 1'b1, 8'hFF);
    chk("full_out", 32'(out_data), 32'h11);
    chk("full_reopen", 32'(in_ready), 32'd1);
    step(1'b1, 8'h33, 1'b0, 8'h00);

    // Simultaneous input and request.
    do_reset();
    step(1'b1, 8'hA3, 1'b0, 8'h00);
    step(1'b1, 8'h55, 1'b1, 8'h0F);
    chk("simul_out", 32'(out_data), 32'h03);
    chk("simul_count", 32'(dut.count_q), 32'd12);
    chk("simul_buf", 32'(dut.buf_q[11:4]), 32'h55);

    // Zero mask on an empty buffer.
    do_reset();
    step(1'b0, 8'h00, 1'b1, 8'h00);
    chk("zero_valid", 32'(out_valid), 32'd1);

    // Reset while an output pulse is live.
    do_reset();
    step(1'b1, 8'hFF, 1'b0, 8'h00);
    step(1'b0, 8'h00, 1'b1, 8'h07);
    chk("mid_count5", 32'(dut.count_q), 32'd5);
    reset = 1'b0;
    #1;
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_out_data", 32'(out_data), 32'd0);
    chk("mid_out_mask", 32'(out_mask), 32'd0);
    do_reset();
    #1;
    chk("mid_count0", 32'(dut.count_q), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);

    // Random traffic; sparse masks now and then so zero/small requests appear.
    for (int c = 0; c < 400; c++) begin
      logic [W-1:0] m;
      m = W'($urandom);
      if ($urandom_range(0, 3) == 0) m = m & W'($urandom);
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
